// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared types and constants for the IO bus controller
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int WAIT_W = 3;
    localparam logic [15:0] CONSOLE_ADDR_DEF = 16'd2222;

endpackage

// File: rtl/io_rr_arb2.sv
// rtl/io_rr_arb2.sv - combinational 2-way round-robin arbiter
module io_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant_valid = |req;
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - two-requester IO bus sequencer with nCS/nOE/nWE strobes
// Optional console port snooping enabled by IO_CONSOLE_EN.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int WAIT_STATES = 1
`ifdef IO_CONSOLE_EN
    ,
    parameter logic [15:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF
`endif
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [15:0] IO_A,
    output logic [7:0]  IO_D_out,
    output logic        IO_D_oe,
    input  logic [7:0]  IO_D_in,
    output logic        nCS,
    output logic        nOE,
    output logic        nWE,
    output logic        con_valid,
    output logic [7:0]  con_char
);

    localparam logic [WAIT_W-1:0] WS = WAIT_STATES[WAIT_W-1:0];

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic              we_r;
    logic              gnt_r;
    logic              last_grant;
    logic              grant;
    logic              grant_valid;

    io_rr_arb2 u_arb (
        .req         ({req1, req0}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign busy = (state != IDLE);

`ifndef IO_CONSOLE_EN
    assign con_valid = 1'b0;
    assign con_char  = 8'h00;
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= IDLE;
            cnt        <= '0;
            we_r       <= 1'b0;
            gnt_r      <= 1'b0;
            last_grant <= 1'b1;
            IO_A       <= 16'h0000;
            IO_D_out   <= 8'h00;
            IO_D_oe    <= 1'b0;
            nCS        <= 1'b1;
            nOE        <= 1'b1;
            nWE        <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= 8'h00;
`ifdef IO_CONSOLE_EN
            con_valid  <= 1'b0;
            con_char   <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state      <= SETUP;
                        gnt_r      <= grant;
                        last_grant <= grant;
                        cnt        <= WS;
                        nCS        <= 1'b0;
                        if (grant) begin
                            IO_A     <= addr1;
                            IO_D_out <= wdata1;
                            we_r     <= we1;
                            IO_D_oe  <= we1;
                        end else begin
                            IO_A     <= addr0;
                            IO_D_out <= wdata0;
                            we_r     <= we0;
                            IO_D_oe  <= we0;
                        end
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    nOE   <= we_r;
                    nWE   <= ~we_r;
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        nCS     <= 1'b1;
                        nOE     <= 1'b1;
                        nWE     <= 1'b1;
                        IO_D_oe <= 1'b0;
                        ack0    <= ~gnt_r;
                        ack1    <= gnt_r;
                        if (!we_r) begin
                            rdata <= IO_D_in;
                        end
`ifdef IO_CONSOLE_EN
                        if (we_r && (IO_A == CONSOLE_ADDR)) begin
                            con_valid <= 1'b1;
                            con_char  <= IO_D_out;
                        end
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
`ifdef IO_CONSOLE_EN
                    con_valid <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - directed self-checking bench for io_bus_ctrl
module tb_io_bus_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        nRESET;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1, IO_D_in;

    logic        ack0, ack1, busy, io_d_oe, ncs, noe, nwe, con_valid;
    logic [7:0]  rdata, io_d_out, con_char;
    logic [15:0] io_a;

    logic        z_ack0, z_ack1, z_busy, z_oe, z_ncs, z_noe, z_nwe, z_cv;
    logic [7:0]  z_rdata, z_dout, z_cc;
    logic [15:0] z_a;

    logic        s_ack0, s_ack1, s_busy, s_oe, s_ncs, s_noe, s_nwe, s_cv;
    logic [7:0]  s_rdata, s_dout, s_cc;
    logic [15:0] s_a;

    int tests = 0;
    int fails = 0;

    io_bus_ctrl #(.WAIT_STATES(1)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .IO_A(io_a), .IO_D_out(io_d_out), .IO_D_oe(io_d_oe), .IO_D_in(IO_D_in),
        .nCS(ncs), .nOE(noe), .nWE(nwe), .con_valid(con_valid), .con_char(con_char)
    );

    io_bus_ctrl #(.WAIT_STATES(0)) dut0 (
        .CLK(CLK), .nRESET(nRESET),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(z_ack0), .ack1(z_ack1), .rdata(z_rdata), .busy(z_busy),
        .IO_A(z_a), .IO_D_out(z_dout), .IO_D_oe(z_oe), .IO_D_in(IO_D_in),
        .nCS(z_ncs), .nOE(z_noe), .nWE(z_nwe), .con_valid(z_cv), .con_char(z_cc)
    );

    io_bus_ctrl #(.WAIT_STATES(7)) dut7 (
        .CLK(CLK), .nRESET(nRESET),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(s_ack0), .ack1(s_ack1), .rdata(s_rdata), .busy(s_busy),
        .IO_A(s_a), .IO_D_out(s_dout), .IO_D_oe(s_oe), .IO_D_in(IO_D_in),
        .nCS(s_ncs), .nOE(s_noe), .nWE(s_nwe), .con_valid(s_cv), .con_char(s_cc)
    );

    int         con_cnt = 0;
    int         strobe_viol = 0;
    logic [7:0] con_log [0:7];

    always @(negedge CLK) begin
        if (con_valid) begin
            con_log[con_cnt[2:0]] = con_char;
            con_cnt = con_cnt + 1;
        end
        if (!noe && !nwe) strobe_viol = strobe_viol + 1;
        if (!noe && io_d_oe) strobe_viol = strobe_viol + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        nRESET = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; IO_D_in = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRESET = 1'b1;
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; IO_D_in = '0;
        @(posedge CLK); #1;
        tests++;
        if ({ncs, noe, nwe} !== 3'b111) begin
            fails++; $display("FAIL reset_strobes got %b want 111", {ncs, noe, nwe});
        end
        tests++;
        if ({io_d_oe, ack0, ack1, busy, con_valid} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b want 00000", {io_d_oe, ack0, ack1, busy, con_valid});
        end
        tests++;
        if ({io_a, io_d_out, rdata, con_char} !== 40'h0) begin
            fails++; $display("FAIL reset_buses got %h want 0", {io_a, io_d_out, rdata, con_char});
        end
        @(negedge CLK);
        nRESET = 1'b1;
        @(posedge CLK); #1;
        tests++;
        if ({busy, ncs} !== 2'b01) begin
            fails++; $display("FAIL reset_idle got %b want 01", {busy, ncs});
        end
    endtask

    task automatic test_read();
        int n_cs, n_oe, n_we, n_ack, cyc_ack;
        logic [15:0] a_seen;
        n_cs = 0; n_oe = 0; n_we = 0; n_ack = 0; cyc_ack = 0; a_seen = '0;
        @(negedge CLK);
        req0 = 1; we0 = 0; addr0 = 16'h0010; IO_D_in = 8'hA5;
        for (int c = 1; c <= 12; c++) begin
            @(posedge CLK); #1;
            if (!ncs) begin n_cs++; if (n_cs == 1) a_seen = io_a; end
            if (!noe) n_oe++;
            if (!nwe) n_we++;
            if (ack0) begin n_ack++; if (cyc_ack == 0) cyc_ack = c; req0 = 0; end
        end
        tests++; if (n_cs !== 3) begin fails++; $display("FAIL read_ncs_width got %0d want 3", n_cs); end
        tests++; if (n_oe !== 2) begin fails++; $display("FAIL read_noe_width got %0d want 2", n_oe); end
        tests++; if (n_we !== 0) begin fails++; $display("FAIL read_nwe_low got %0d want 0", n_we); end
        tests++; if (cyc_ack !== 4) begin fails++; $display("FAIL read_ack_latency got %0d want 4", cyc_ack); end
        tests++; if (n_ack !== 1) begin fails++; $display("FAIL read_ack_count got %0d want 1", n_ack); end
        tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL read_rdata got %h want a5", rdata); end
        tests++; if (a_seen !== 16'h0010) begin fails++; $display("FAIL read_addr got %h want 0010", a_seen); end
    endtask

    task automatic test_write();
        int n_oe, n_we, n_doe, n_ack0, n_ack1, n_cs;
        logic [15:0] a_seen;
        logic [7:0]  d_seen;
        n_oe = 0; n_we = 0; n_doe = 0; n_ack0 = 0; n_ack1 = 0; n_cs = 0;
        a_seen = '0; d_seen = '0;
        @(negedge CLK);
        req1 = 1; we1 = 1; addr1 = 16'h1234; wdata1 = 8'h3C; IO_D_in = 8'h77;
        for (int c = 1; c <= 12; c++) begin
            @(posedge CLK); #1;
            if (!ncs) begin n_cs++; if (n_cs == 1) begin a_seen = io_a; d_seen = io_d_out; end end
            if (!noe) n_oe++;
            if (!nwe) n_we++;
            if (io_d_oe) n_doe++;
            if (ack0) n_ack0++;
            if (ack1) begin n_ack1++; req1 = 0; end
        end
        tests++; if (a_seen !== 16'h1234) begin fails++; $display("FAIL write_addr got %h want 1234", a_seen); end
        tests++; if (d_seen !== 8'h3C) begin fails++; $display("FAIL write_data got %h want 3c", d_seen); end
        tests++; if (n_doe !== 3) begin fails++; $display("FAIL write_oe_width got %0d want 3", n_doe); end
        tests++; if (n_we !== 2) begin fails++; $display("FAIL write_nwe_width got %0d want 2", n_we); end
        tests++; if (n_oe !== 0) begin fails++; $display("FAIL write_noe_low got %0d want 0", n_oe); end
        tests++; if ({n_ack1, n_ack0} !== {32'd1, 32'd0}) begin
            fails++; $display("FAIL write_acks got ack1=%0d ack0=%0d want 1 0", n_ack1, n_ack0);
        end
        tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL write_rdata_hold got %h want a5", rdata); end
    endtask

    task automatic test_contention();
        int k, both;
        logic [3:0] who;
        int when [4];
        k = 0; both = 0; who = '0;
        for (int i = 0; i < 4; i++) when[i] = 0;
        apply_reset();
        @(negedge CLK);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0100; addr1 = 16'h0200; IO_D_in = 8'h11;
        for (int c = 1; c <= 22; c++) begin
            @(posedge CLK); #1;
            if (ack0 && ack1) both++;
            if ((ack0 || ack1) && k < 4) begin who[k] = ack1; when[k] = c; k++; end
        end
        req0 = 0; req1 = 0;
        tests++; if (both !== 0) begin fails++; $display("FAIL cont_dual_ack got %0d want 0", both); end
        tests++; if (who !== 4'b1010) begin fails++; $display("FAIL cont_order got %b want 1010", who); end
        tests++; if (when[0] !== 4) begin fails++; $display("FAIL cont_ack0_first got %0d want 4", when[0]); end
        tests++; if (when[1] !== 9) begin fails++; $display("FAIL cont_ack1_first got %0d want 9", when[1]); end
        tests++; if (when[2] !== 14) begin fails++; $display("FAIL cont_ack0_second got %0d want 14", when[2]); end
        tests++; if (when[3] !== 19) begin fails++; $display("FAIL cont_ack1_second got %0d want 19", when[3]); end
        tests++; if (when[2] - when[0] !== 10) begin
            fails++; $display("FAIL cont_gap got %0d want 10", when[2] - when[0]);
        end
        repeat (4) @(posedge CLK);
    endtask

    task automatic test_wait_states();
        int z_w, z_lat, s_w, s_lat;
        bit z_done, s_done;
        z_w = 0; z_lat = 0; s_w = 0; s_lat = 0; z_done = 0; s_done = 0;
        apply_reset();
        @(negedge CLK);
        req0 = 1; we0 = 0; addr0 = 16'h0020; IO_D_in = 8'h5A;
        for (int c = 1; c <= 14; c++) begin
            @(posedge CLK); #1;
            if (!z_done) begin
                if (!z_noe) z_w++;
                if (z_ack0) begin z_lat = c; z_done = 1; end
            end
            if (!s_done) begin
                if (!s_noe) s_w++;
                if (s_ack0) begin s_lat = c; s_done = 1; req0 = 0; end
            end
        end
        tests++; if (z_w !== 1) begin fails++; $display("FAIL ws0_strobe got %0d want 1", z_w); end
        tests++; if (z_lat !== 3) begin fails++; $display("FAIL ws0_latency got %0d want 3", z_lat); end
        tests++; if (s_w !== 8) begin fails++; $display("FAIL ws7_strobe got %0d want 8", s_w); end
        tests++; if (s_lat !== 10) begin fails++; $display("FAIL ws7_latency got %0d want 10", s_lat); end
        tests++; if ({z_rdata, s_rdata} !== 16'h5A5A) begin
            fails++; $display("FAIL ws_rdata got %h %h want 5a 5a", z_rdata, s_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int n_ack, first;
        logic who;
        n_ack = 0; first = 0; who = 1'b1;
        apply_reset();
        @(negedge CLK);
        req0 = 1; we0 = 0; addr0 = 16'h0030; IO_D_in = 8'hC3;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        tests++; if (noe !== 1'b0) begin fails++; $display("FAIL mid_in_strobe got noe=%b want 0", noe); end
        #2;
        nRESET = 1'b0;
        #1;
        tests++; if ({ncs, noe, nwe} !== 3'b111) begin
            fails++; $display("FAIL mid_async_strobes got %b want 111", {ncs, noe, nwe});
        end
        req0 = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            if (ack0 || ack1) n_ack++;
        end
        tests++; if (n_ack !== 0) begin fails++; $display("FAIL mid_no_ack got %0d want 0", n_ack); end
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
        req0 = 1; req1 = 1; we1 = 0; addr1 = 16'h0040;
        for (int c = 1; c <= 8; c++) begin
            @(posedge CLK); #1;
            if ((ack0 || ack1) && first == 0) begin
                first = c; who = ack1; req0 = 0; req1 = 0;
            end
        end
        req0 = 0; req1 = 0;
        tests++; if (first !== 4) begin fails++; $display("FAIL mid_recover_latency got %0d want 4", first); end
        tests++; if (who !== 1'b0) begin fails++; $display("FAIL mid_recover_grant got %b want 0", who); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a_tab [3];
        logic [7:0]  d_tab [3];
        int start;
        bit got;
        a_tab[0] = 16'd2222; a_tab[1] = 16'd2222; a_tab[2] = 16'd2223;
        d_tab[0] = 8'h48;    d_tab[1] = 8'h69;    d_tab[2] = 8'h78;
        apply_reset();
        start = con_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            req0 = 1; we0 = 1; addr0 = a_tab[i]; wdata0 = d_tab[i];
            got = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge CLK); #1;
                if (ack0) begin got = 1; break; end
            end
            req0 = 0;
            tests++; if (!got) begin fails++; $display("FAIL b2b_ack_timeout xfer %0d got none want ack0", i); end
            @(posedge CLK);
        end
        repeat (3) @(posedge CLK);
        #1;
`ifdef IO_CONSOLE_EN
        tests++; if (con_cnt - start !== 2) begin
            fails++; $display("FAIL con_pulses got %0d want 2", con_cnt - start);
        end
        tests++; if (con_log[start[2:0]] !== 8'h48) begin
            fails++; $display("FAIL con_char0 got %h want 48", con_log[start[2:0]]);
        end
        tests++; if (con_log[start[2:0] + 3'd1] !== 8'h69) begin
            fails++; $display("FAIL con_char1 got %h want 69", con_log[start[2:0] + 3'd1]);
        end
        tests++; if (con_char !== 8'h69) begin fails++; $display("FAIL con_char_hold got %h want 69", con_char); end
`else
        tests++; if (con_cnt !== 0) begin fails++; $display("FAIL con_disabled_pulses got %0d want 0", con_cnt); end
        tests++; if (con_char !== 8'h00) begin fails++; $display("FAIL con_disabled_char got %h want 00", con_char); end
`endif
        tests++; if (strobe_viol !== 0) begin
            fails++; $display("FAIL strobe_overlap got %0d want 0", strobe_viol);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
